fetch_queue: RTL



---
 rtl/fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, variable-latency imem port and a prefetch FIFO.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_queue #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_0000,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_killed
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]    DepthC = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] StepC  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_q, resp_pc_q;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, inflight_q, kill_q;

  logic [CNT_W:0] credit;
  logic           grant, rsp_ok, drop, push, pop;

  assign credit    = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_addr = pc_q;

  always_comb begin
    // Credit rule: never have more requests outstanding than free FIFO slots.
    imem_req = !rst && !redirect_valid && (credit < DepthC);
    grant    = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok   = imem_rvalid && (inflight_q != '0);
    drop     = rsp_ok && (redirect_valid || (kill_q != '0));
    push     = rsp_ok && !drop;
    id_valid = (count_q != '0);
    pop      = id_valid && id_ready && !redirect_valid;
    id_inst  = id_valid ? data_mem[rd_ptr_q] : '0;
    id_pc    = id_valid ? pc_mem[rd_ptr_q]   : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      inflight_q <= inflight_q + CNT_W'(grant) - CNT_W'(rsp_ok);
      if (redirect_valid) begin
        pc_q      <= redirect_pc;
        resp_pc_q <= redirect_pc;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        kill_q    <= inflight_q - CNT_W'(rsp_ok);
      end else begin
        if (grant) pc_q <= pc_q + StepC;
        if (drop)  kill_q <= kill_q - CNT_W'(1);
        if (push) begin
          resp_pc_q <= resp_pc_q + StepC;
          wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, killed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      killed_q  <= '0;
    end else begin
      if (pop) fetched_q <= fetched_q + 32'd1;
      // A redirect flushes every buffered entry plus any response arriving with it.
      if (redirect_valid)  killed_q <= killed_q + 32'(count_q) + 32'(rsp_ok);
      else if (drop)       killed_q <= killed_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;
`else
  assign perf_fetched = '0;
  assign perf_killed  = '0;
`endif

  // Stale responses right after reset (pc still at RESET_PC) are tolerated.
  rvalid_has_req: assert property (@(posedge clk) disable iff (rst)
    (imem_rvalid && (pc_q != RESET_PC)) |-> (inflight_q != '0));

endmodule
